tx_conv_encoder: RTL and testbench



---
 rtl/tx_phy_pkg.sv | 48 ++++
 rtl/conv_enc_k7.sv | 37 +++
 rtl/tx_conv_encoder.sv | 221 ++++++++++++++++++++++
 tb/tb_tx_conv_encoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tx_phy_pkg.sv
// Shared transmit-PHY definitions: RATE codes, K=7 generator taps,
// puncture modes, encoder FSM states and small helper functions.
package tx_phy_pkg;

    // SIGNAL-field RATE codes (first received bit is the MSB)
    localparam logic [3:0] RATE_6  = 4'b1101;
    localparam logic [3:0] RATE_9  = 4'b1111;
    localparam logic [3:0] RATE_12 = 4'b0101;
    localparam logic [3:0] RATE_18 = 4'b0111;
    localparam logic [3:0] RATE_24 = 4'b1001;
    localparam logic [3:0] RATE_36 = 4'b1011;
    localparam logic [3:0] RATE_48 = 4'b0001;
    localparam logic [3:0] RATE_54 = 4'b0011;

    // Generator polynomials; bit 6 taps the current input, bit 0 the oldest.
    localparam logic [6:0] G0 = 7'o133;
    localparam logic [6:0] G1 = 7'o171;

    typedef enum logic [1:0] {
        P12,
        P23,
        P34
    } punct_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_SIG,
        ST_DATA
    } tx_state_e;

    // Unknown codes fall back to the most robust rate.
    function automatic punct_e rate_to_punct(input logic [3:0] rate);
        punct_e mode;
        case (rate)
            RATE_48:                            mode = P23;
            RATE_9, RATE_18, RATE_36, RATE_54:  mode = P34;
            default:                            mode = P12;
        endcase
        return mode;
    endfunction

    // Parity of the tapped window {d, s1..s6}.
    function automatic logic conv_bit(input logic [6:0] win, input logic [6:0] gen);
        return ^(win & gen);
    endfunction

endpackage

// File: rtl/conv_enc_k7.sv
// Bit-serial K=7 rate-1/2 convolutional encoder. Outputs are combinational
// from the current input and history; the history advances only on en and
// a synchronous clear wins over enable.
module conv_enc_k7
    import tx_phy_pkg::*;
(
    input  logic clk,
    input  logic en,
    input  logic clr,
    input  logic d,
    output logic a,
    output logic b
);

    // sr_q[5] is s1 (previous bit), sr_q[0] is s6 (oldest)
    logic [5:0] sr_q;
    logic [5:0] sr_d;

    // Next history: clear, shift in the new bit, or hold
    always_comb begin
        sr_d = sr_q;
        if (clr) begin
            sr_d = '0;
        end else if (en) begin
            sr_d = {d, sr_q[5:1]};
        end
    end

    // History register
    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end

    assign a = conv_bit({d, sr_q}, G0);
    assign b = conv_bit({d, sr_q}, G1);

endmodule

// File: rtl/tx_conv_encoder.sv
// Convolutional encoder and puncturer for the transmit stream.
// Passes the preamble uncoded, codes SIGNAL at rate 1/2, captures RATE from
// the first four SIGNAL bits and punctures DATA accordingly.
// Build option: define TX_CONV_PUNCTURE_EN to build the puncture logic;
// without it DATA pairs always carry mask 11.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | waiting for iValid; first valid bit is preamble bit 0
// ST_PRE  | preamble bits 1..PRE_LEN-1 passed uncoded on A
// ST_SIG  | SIGNAL bits coded at rate 1/2, RATE shifted in
// ST_DATA | SERVICE/DATA/TAIL/PAD coded and punctured
module tx_conv_encoder
    import tx_phy_pkg::*;
#(
    parameter int PRE_LEN = 12,
    parameter int SIG_LEN = 24
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iValid,
    input  logic       iData,
    output logic       oValid,
    output logic       oA,
    output logic       oB,
    output logic [1:0] oMask,
    output logic [3:0] oRate
);

    localparam logic [5:0] PRE_LAST = 6'(PRE_LEN - 1);
    localparam logic [5:0] SIG_LAST = 6'(SIG_LEN - 1);

    tx_state_e  state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [3:0] rate_sh_q, rate_sh_d;
    logic [3:0] rate_q, rate_d;
    logic       valid_q, valid_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic [1:0] mask_q, mask_d;

    logic       enc_en;
    logic       enc_clr;
    logic       enc_a;
    logic       enc_b;
    logic       sig_done;
    logic [1:0] data_mask;

    conv_enc_k7 u_enc (
        .clk (iClk),
        .en  (enc_en),
        .clr (enc_clr | iRst),
        .d   (iData),
        .a   (enc_a),
        .b   (enc_b)
    );

    // Next state, bit counter, RATE capture and encoder control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rate_sh_d = rate_sh_q;
        rate_d    = rate_q;
        enc_en    = 1'b0;
        enc_clr   = 1'b0;
        sig_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                enc_clr = 1'b1;
                if (iValid) begin
                    state_d = ST_PRE;
                    cnt_d   = 6'd1;
                end
            end
            ST_PRE: begin
                enc_clr = 1'b1;
                if (!iValid) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == PRE_LAST) begin
                    state_d = ST_SIG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_SIG: begin
                if (!iValid) begin
                    state_d = ST_IDLE;
                    enc_clr = 1'b1;
                end else begin
                    enc_en = 1'b1;
                    if (cnt_q < 6'd4) begin
                        rate_sh_d = {rate_sh_q[2:0], iData};
                    end
                    if (cnt_q == SIG_LAST) begin
                        // DATA is coded from a fresh zero history
                        state_d  = ST_DATA;
                        cnt_d    = '0;
                        enc_clr  = 1'b1;
                        rate_d   = rate_sh_d;
                        sig_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            ST_DATA: begin
                if (!iValid) begin
                    state_d = ST_IDLE;
                end else begin
                    enc_en = 1'b1;
                    cnt_d  = cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef TX_CONV_PUNCTURE_EN
    punct_e     punct_q, punct_d;
    logic [1:0] ph_q, ph_d;

    // Puncture mode latch and phase counter wrapping at the puncture period
    always_comb begin
        punct_d   = punct_q;
        ph_d      = ph_q;
        data_mask = 2'b11;
        if (sig_done) begin
            punct_d = rate_to_punct(rate_sh_d);
            ph_d    = '0;
        end else if (state_q == ST_DATA && iValid) begin
            case (punct_q)
                P23: begin
                    data_mask = (ph_q == 2'd0) ? 2'b11 : 2'b10;
                    ph_d      = (ph_q == 2'd1) ? 2'd0 : ph_q + 2'd1;
                end
                P34: begin
                    data_mask = (ph_q == 2'd0) ? 2'b11 : (ph_q == 2'd1) ? 2'b10 : 2'b01;
                    ph_d      = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
                end
                default: begin
                    data_mask = 2'b11;
                    ph_d      = '0;
                end
            endcase
        end
    end

    // Puncture state registers
    always_ff @(posedge iClk) begin
        if (iRst) begin
            punct_q <= P12;
            ph_q    <= '0;
        end else begin
            punct_q <= punct_d;
            ph_q    <= ph_d;
        end
    end
`else
    assign data_mask = 2'b11;
`endif

    // Output pair selection; everything reads zero when no bit is consumed
    always_comb begin
        valid_d = 1'b0;
        a_d     = 1'b0;
        b_d     = 1'b0;
        mask_d  = 2'b00;
        if (iValid) begin
            valid_d = 1'b1;
            case (state_q)
                ST_IDLE, ST_PRE: begin
                    a_d    = iData;
                    mask_d = 2'b10;
                end
                ST_SIG: begin
                    a_d    = enc_a;
                    b_d    = enc_b;
                    mask_d = 2'b11;
                end
                default: begin
                    a_d    = enc_a;
                    b_d    = enc_b;
                    mask_d = data_mask;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rate_sh_q <= '0;
            rate_q    <= '0;
            valid_q   <= 1'b0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            mask_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rate_sh_q <= rate_sh_d;
            rate_q    <= rate_d;
            valid_q   <= valid_d;
            a_q       <= a_d;
            b_q       <= b_d;
            mask_q    <= mask_d;
        end
    end

    assign oValid = valid_q;
    assign oA     = a_q;
    assign oB     = b_q;
    assign oMask  = mask_q;
    assign oRate  = rate_q;

endmodule

// File: tb/tb_tx_conv_encoder.sv
// Testbench for tx_conv_encoder: directed packet sequence with random
// payload bits, checked against a convolution/puncture reference model.
module tb_tx_conv_encoder;

    localparam logic [6:0] TG0 = 7'o133;
    localparam logic [6:0] TG1 = 7'o171;

    logic       clk;
    logic       iRst;
    logic       iValid;
    logic       iData;
    logic       oValid;
    logic       oA;
    logic       oB;
    logic [1:0] oMask;
    logic [3:0] oRate;

    int         checks;
    int         failures;
    int         n_kept;
    logic [3:0] last_rate;
    logic       pkt[$];
    logic [7:0] cap_a;
    logic [7:0] cap_b;

    tx_conv_encoder #(.PRE_LEN(12), .SIG_LEN(24)) dut (
        .iClk   (clk),
        .iRst   (iRst),
        .iValid (iValid),
        .iData  (iData),
        .oValid (oValid),
        .oA     (oA),
        .oB     (oB),
        .oMask  (oMask),
        .oRate  (oRate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic d, input logic r);
        @(negedge clk);
        iValid = v;
        iData  = d;
        iRst   = r;
        @(posedge clk);
        #1;
    endtask

    // Output bit k of a segment starting at base: sum over the taps of g
    // of the input j bits earlier, zero before the segment start.
    function automatic logic par(input int base, input int k, input logic [6:0] g);
        logic x;
        x = 1'b0;
        for (int j = 0; j < 7; j++) begin
            if (g[6-j] && (k - j) >= 0) x = x ^ pkt[base + k - j];
        end
        return x;
    endfunction

    function automatic logic [1:0] exp_mask(input logic [3:0] r, input int k);
        logic [1:0] m;
`ifdef TX_CONV_PUNCTURE_EN
        int period;
        period = 1;
        if (r == 4'b0001) period = 2;
        else if (r == 4'b1111 || r == 4'b0111 || r == 4'b1011 || r == 4'b0011) period = 3;
        case (k % period)
            0:       m = 2'b11;
            1:       m = 2'b10;
            default: m = 2'b01;
        endcase
`else
        m = 2'b11;
`endif
        return m;
    endfunction

    function automatic void build(input logic [11:0] pre, input logic [3:0] rate, input int nd);
        pkt.delete();
        for (int i = 0; i < 12; i++) pkt.push_back(pre[11-i]);
        for (int i = 0; i < 4; i++) pkt.push_back(rate[3-i]);
        for (int i = 0; i < 20; i++) pkt.push_back(1'($urandom_range(1, 0)));
        for (int i = 0; i < nd; i++) pkt.push_back(1'($urandom_range(1, 0)));
    endfunction

    // Drive the first n bits of pkt and check every output pair.
    task automatic play(input int n);
        logic       ea, eb;
        logic [1:0] em;
        logic [3:0] r;
        int         k;
        n_kept = 0;
        r = {pkt[12], pkt[13], pkt[14], pkt[15]};
        for (int i = 0; i < n; i++) begin
            step(1'b1, pkt[i], 1'b0);
            if (i < 12) begin
                ea = pkt[i];
                eb = 1'b0;
                em = 2'b10;
            end else if (i < 36) begin
                k  = i - 12;
                ea = par(12, k, TG0);
                eb = par(12, k, TG1);
                em = 2'b11;
                if (k < 8) begin
                    cap_a[7-k] = oA;
                    cap_b[7-k] = oB;
                end
            end else begin
                k  = i - 36;
                ea = par(36, k, TG0);
                eb = par(36, k, TG1);
                em = exp_mask(r, k);
                n_kept += int'(em[1]) + int'(em[0]);
                last_rate = r;
                chk($sformatf("rate_bit%0d", i), {4'h0, oRate}, {4'h0, r});
            end
            chk($sformatf("pair_bit%0d", i), {3'b000, oValid, oA, oB, oMask},
                {3'b000, 1'b1, ea, eb, em});
        end
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'($urandom_range(1, 0)), 1'b0);
        chk({tag, "_out"}, {3'b000, oValid, oA, oB, oMask}, 8'h00);
        chk({tag, "_rate"}, {4'h0, oRate}, {4'h0, last_rate});
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        n_kept    = 0;
        last_rate = 4'h0;
        cap_a     = 8'h00;
        cap_b     = 8'h00;
        iRst      = 1'b1;
        iValid    = 1'b0;
        iData     = 1'b0;

        // Reset, with iValid high to show reset priority
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("reset_out", {3'b000, oValid, oA, oB, oMask}, 8'h00);
        chk("reset_rate", {4'h0, oRate}, 8'h00);
        idle("post_reset");

        // Preamble all ones, SIGNAL impulse (RATE 1000 -> rate 1/2)
        build(12'hFFF, 4'b1000, 8);
        for (int i = 13; i < 36; i++) pkt[i] = 1'b0;
        play(36 + 8);
        chk("impulse_a", cap_a, 8'b10110110);
        chk("impulse_b", cap_b, 8'b11110010);
        chk("kept_unknown", 8'(n_kept), 8'd16);
        idle("gap1");

        // RATE 1111: 3/4 puncturing over 12 data bits
        build(12'($urandom), 4'b1111, 12);
        play(36 + 12);
`ifdef TX_CONV_PUNCTURE_EN
        chk("kept_r34", 8'(n_kept), 8'd16);
`else
        chk("kept_r34", 8'(n_kept), 8'd24);
`endif
        idle("gap2");

        // Back-to-back: RATE 0001, 2/3 puncturing
        build(12'($urandom), 4'b0001, 12);
        play(36 + 12);
`ifdef TX_CONV_PUNCTURE_EN
        chk("kept_r23", 8'(n_kept), 8'd18);
`else
        chk("kept_r23", 8'(n_kept), 8'd24);
`endif
        idle("gap3");

        // Unknown RATE 0000 decodes as rate 1/2
        build(12'($urandom), 4'b0000, 10);
        play(36 + 10);
        chk("kept_r0000", 8'(n_kept), 8'd20);
        idle("gap4");

        // iValid dropped at SIGNAL bit 10, then a clean packet
        build(12'($urandom), 4'b1011, 6);
        play(12 + 10);
        idle("abort_sig");
        build(12'($urandom), 4'b1101, 9);
        play(36 + 9);
        idle("gap5");

        // Reset pulsed mid-DATA, then a packet from a zero encoder state
        build(12'($urandom), 4'b0011, 12);
        play(36 + 5);
        step(1'b1, 1'b1, 1'b1);
        last_rate = 4'h0;
        chk("rst_data_out", {3'b000, oValid, oA, oB, oMask}, 8'h00);
        chk("rst_data_rate", {4'h0, oRate}, 8'h00);
        idle("after_rst");
        build(12'($urandom), 4'b0111, 12);
        play(36 + 12);
        idle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
